// File: rtl/receiver_if.sv
// Serial-link and parallel-consumer signals of the receiver.
// slave = receiver side, master = the agent driving MOSI/SH/RD.
interface receiver_if;
    logic       MOSI;
    logic       SH;
    logic       RD;
    logic [7:0] DATA;
    logic       FULL_STATE;
    logic       EMPTY_STATE;
    logic       OVERRUN;
    logic       PERR;

    modport slave (
        input  MOSI, SH, RD,
        output DATA, FULL_STATE, EMPTY_STATE, OVERRUN, PERR
    );

    modport master (
        output MOSI, SH, RD,
        input  DATA, FULL_STATE, EMPTY_STATE, OVERRUN, PERR
    );
endinterface

// File: rtl/receiver.sv
// Serial-to-parallel receiver: MSB-first byte assembly into a DEPTH-entry FIFO.
// Optional even-parity frame bit enabled by defining RECEIVER_PARITY_EN.
module receiver #(
    parameter int DEPTH = 4
) (
    input  logic     SCLK,
    input  logic     CLR,
    receiver_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef RECEIVER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif
    localparam logic [3:0]  LAST_BIT = 4'(FL - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    shift_q, shift_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovr_q, ovr_d;
    logic          perr_q, perr_d;
    logic [7:0]    mem_q [DEPTH];

    logic       full, empty;
    logic       frame_done;
    logic [7:0] rx_byte;
    logic       pop, push;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    assign frame_done = bus.SH && (cnt_q == LAST_BIT);
`ifdef RECEIVER_PARITY_EN
    // Data bits already sit in the shifter; the bit on MOSI is the parity bit.
    assign rx_byte = shift_q;
`else
    assign rx_byte = {shift_q[6:0], bus.MOSI};
`endif

    assign pop  = bus.RD && !empty;
    // A full FIFO still accepts the byte when a pop frees a slot on the same edge.
    assign push = frame_done && (!full || pop);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        perr_d  = perr_q;

        if (bus.SH) begin
            shift_d = {shift_q[6:0], bus.MOSI};
            cnt_d   = frame_done ? 4'd0 : cnt_q + 4'd1;
        end else begin
            cnt_d = 4'd0;
        end

        if (frame_done && !push) begin
            ovr_d = 1'b1;
        end
`ifdef RECEIVER_PARITY_EN
        if (frame_done && ((^shift_q) ^ bus.MOSI)) begin
            perr_d = 1'b1;
        end
`endif

        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge SCLK) begin
        if (CLR) begin
            shift_q <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    // Storage carries no reset; DATA is masked while the FIFO is empty.
    always_ff @(posedge SCLK) begin
        if (!CLR && push) begin
            mem_q[wptr_q] <= rx_byte;
        end
    end

    assign bus.DATA        = empty ? 8'h00 : mem_q[rptr_q];
    assign bus.FULL_STATE  = full;
    assign bus.EMPTY_STATE = empty;
    assign bus.OVERRUN     = ovr_q;
    assign bus.PERR        = perr_q;
endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: expected bytes queued at send time, checked by a pop monitor.
module tb_receiver;
    logic SCLK = 1'b0;
    logic CLR  = 1'b0;

    receiver_if bus ();
    receiver #(.DEPTH(4)) dut (.SCLK(SCLK), .CLR(CLR), .bus(bus));

    always #5 SCLK = ~SCLK;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pops happen on the rising edge; the head byte is checked just before it.
    always @(negedge SCLK) begin
        if (!CLR && bus.RD === 1'b1 && bus.EMPTY_STATE === 1'b0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %h expected none", bus.DATA);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.DATA !== e) begin
                    bad++;
                    $display("FAIL pop_data: got %h expected %h", bus.DATA, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    task automatic clr_pulse();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
    endtask

    // Sends one frame; rd_last raises RD on the edge that samples the last bit.
    task automatic send_frame(input logic [7:0] b, input logic par, input bit rd_last,
                              input bit expect_push);
        for (int i = 7; i >= 0; i--) begin
            bus.MOSI = b[i];
            bus.SH   = 1'b1;
`ifdef RECEIVER_PARITY_EN
            bus.RD   = 1'b0;
`else
            bus.RD   = rd_last && (i == 0);
`endif
            tick();
        end
`ifdef RECEIVER_PARITY_EN
        bus.MOSI = par;
        bus.RD   = rd_last;
        tick();
`else
        if (par) begin end
`endif
        if (expect_push) exp_q.push_back(b);
        bus.SH = 1'b0;
        bus.RD = 1'b0;
    endtask

    task automatic pop_n(input int n);
        bus.RD = 1'b1;
        repeat (n) tick();
        bus.RD = 1'b0;
    endtask

    initial begin
        bus.MOSI = 1'b0;
        bus.SH   = 1'b0;
        bus.RD   = 1'b0;
        tick();

        // Reset state
        clr_pulse();
        check("rst_data",  bus.DATA, 8'h00);
        check("rst_empty", 8'(bus.EMPTY_STATE), 8'd1);
        check("rst_full",  8'(bus.FULL_STATE), 8'd0);
        check("rst_ovr",   8'(bus.OVERRUN), 8'd0);
        check("rst_perr",  8'(bus.PERR), 8'd0);

        // Single byte, visible on its last edge
        send_frame(8'hA5, 1'b0, 0, 1);
        check("a5_data",  bus.DATA, 8'hA5);
        check("a5_empty", 8'(bus.EMPTY_STATE), 8'd0);
        check("a5_full",  8'(bus.FULL_STATE), 8'd0);
        pop_n(1);
        check("a5_empty_after", 8'(bus.EMPTY_STATE), 8'd1);

        // Fill to DEPTH, then overrun
        send_frame(8'h11, 1'b0, 0, 1);
        send_frame(8'h22, 1'b0, 0, 1);
        send_frame(8'h33, 1'b0, 0, 1);
        send_frame(8'h44, 1'b0, 0, 1);
        check("fill_full", 8'(bus.FULL_STATE), 8'd1);
        check("fill_data", bus.DATA, 8'h11);
        check("fill_ovr0", 8'(bus.OVERRUN), 8'd0);
        send_frame(8'h55, 1'b0, 0, 0);
        check("ovr_set",  8'(bus.OVERRUN), 8'd1);
        check("ovr_data", bus.DATA, 8'h11);
        pop_n(4);
        check("drain_empty", 8'(bus.EMPTY_STATE), 8'd1);
        check("ovr_sticky",  8'(bus.OVERRUN), 8'd1);

        // Full FIFO, last bit coincides with a pop
        clr_pulse();
        send_frame(8'h11, 1'b0, 0, 1);
        send_frame(8'h22, 1'b0, 0, 1);
        send_frame(8'h33, 1'b0, 0, 1);
        send_frame(8'h44, 1'b0, 0, 1);
        send_frame(8'h55, 1'b0, 1, 1);
        check("pp_ovr",  8'(bus.OVERRUN), 8'd0);
        check("pp_full", 8'(bus.FULL_STATE), 8'd1);
        check("pp_data", bus.DATA, 8'h22);
        pop_n(4);
        check("pp_empty", 8'(bus.EMPTY_STATE), 8'd1);

        // Partial byte discarded when SH drops
        for (int i = 0; i < 5; i++) begin
            bus.MOSI = 1'b1;
            bus.SH   = 1'b1;
            tick();
        end
        bus.SH = 1'b0;
        tick();
        send_frame(8'h3C, 1'b0, 0, 1);
        check("part_data", bus.DATA, 8'h3C);
        tick();
        check("part_full", 8'(bus.FULL_STATE), 8'd0);
        pop_n(1);
        check("part_single", 8'(bus.EMPTY_STATE), 8'd1);

        // CLR mid-byte with bytes queued (OVERRUN set first so the clear is visible)
        send_frame(8'h01, 1'b0, 0, 1);
        send_frame(8'h02, 1'b0, 0, 1);
        send_frame(8'h03, 1'b0, 0, 1);
        send_frame(8'h04, 1'b0, 0, 1);
        send_frame(8'h05, 1'b0, 0, 0);
        check("pre_clr_ovr", 8'(bus.OVERRUN), 8'd1);
        pop_n(2);
        for (int i = 0; i < 4; i++) begin
            bus.MOSI = i[0];
            bus.SH   = 1'b1;
            tick();
        end
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        bus.SH = 1'b0;
        exp_q.delete();
        check("clr_empty", 8'(bus.EMPTY_STATE), 8'd1);
        check("clr_data",  bus.DATA, 8'h00);
        check("clr_ovr",   8'(bus.OVERRUN), 8'd0);
        tick();
        send_frame(8'hC3, 1'b0, 0, 1);
        check("c3_data", bus.DATA, 8'hC3);
        pop_n(1);

`ifdef RECEIVER_PARITY_EN
        // Even parity: 03 with parity 0 is good, 01 with parity 0 is bad
        send_frame(8'h03, 1'b0, 0, 1);
        check("par_ok", 8'(bus.PERR), 8'd0);
        send_frame(8'h01, 1'b0, 0, 1);
        check("par_bad", 8'(bus.PERR), 8'd1);
        pop_n(2);
        check("par_sticky", 8'(bus.PERR), 8'd1);
        clr_pulse();
        check("par_clr", 8'(bus.PERR), 8'd0);
`else
        check("perr_tied", 8'(bus.PERR), 8'd0);
`endif

        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drained: got %0d left expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/receiver.md
# receiver

Serial-to-parallel receiver at the far end of the team's shift-register link: it samples the serial stream the sender drives on MOSI, assembles MSB-first bytes, and queues them in a small FIFO for a parallel consumer. It runs on the same SCLK as the sender. Its shift-enable is driven from the sender's SH_LD, so one byte is received per eight shift cycles. Status flags mirror the sender's FULL_STATE/EMPTY_STATE convention, plus a sticky overrun indicator.

## Interface
- DEPTH, 4, FIFO depth in bytes; power of two, ≥ 2.
- SCLK  input  1  system/shift clock; all state changes on rising edge.
- CLR  input  1  reset, synchronous, active-high; clears shifter, bit counter, FIFO, all flags.
- MOSI  input  1  serial data from sender, MSB first.
- SH  input  1  shift enable (tied to sender SH_LD); 1 = sample MOSI this edge.
- RD  input  1  pop request; acts only when EMPTY_STATE = 0.
- DATA  output  8  FIFO head byte; 8'h00 whenever EMPTY_STATE = 1.
- FULL_STATE  output  1  1 when FIFO holds DEPTH bytes.
- EMPTY_STATE  output  1  1 when FIFO holds 0 bytes.
- OVERRUN  output  1  sticky; a completed byte was dropped because the FIFO was full.
- PERR  output  1  sticky parity error (see Configuration); constant 0 when the feature is compiled out.

## Operation
- Shifter: on each edge with SH = 1, shift_reg <= {shift_reg[6:0], MOSI}; bit counter increments.
- Frame length FL = 8 (9 with parity). The edge that captures bit FL-1 completes the byte: the byte {shift_reg[6:0], MOSI} is pushed, counter returns to 0.
- SH = 0 mid-byte: partial byte discarded, counter returns to 0 on that edge; no push, no flag.
- FIFO: circular buffer, read/write pointers of log2(DEPTH) bits plus an occupancy count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Pop: RD = 1 and EMPTY_STATE = 0 advance the read pointer. RD while empty is ignored.
- Push while full:
  - If a valid pop occurs on the same edge, the push is accepted and the count is unchanged.
  - Otherwise the byte is dropped and OVERRUN <= 1.
- Push and pop on the same edge when not full: both act, count unchanged; DATA moves to the next byte.
- OVERRUN and PERR clear only on CLR.
- Priority: CLR > push/pop > shift.

## Timing
- Reset values, one edge after CLR = 1:
  - DATA = 8'h00, EMPTY_STATE = 1, FULL_STATE = 0, OVERRUN = 0, PERR = 0.
  - Counter = 0, shift_reg = 0.
- CLR during a partial byte aborts it. Reception restarts at bit 0 on the first SH = 1 edge after CLR falls.
- Latency: the byte is visible on DATA and EMPTY_STATE falls on the same edge that samples its last bit. No extra pipeline stage.
- FULL_STATE, EMPTY_STATE and DATA are updated at the edge that changes the occupancy, and are valid for the following cycle.
- Back-to-back frames with SH held high need no gap cycle.

## Configuration
- Macro: RECEIVER_PARITY_EN.
- Defined:
  - FL = 9; the ninth bit is an even-parity bit over the 8 data bits.
  - On completion the 8 data bits are pushed regardless of parity. PERR <= 1 if the XOR of all 9 bits is 1.
  - Dropping SH after 8 bits counts as a partial frame and is discarded.
- Undefined: FL = 8, no parity logic, PERR tied to 0.

## Test plan
- CLR for 1 cycle, then shift 8'hA5 MSB-first (SH = 1 for 8 edges) -> after the 8th edge DATA = 8'hA5, EMPTY_STATE = 0, FULL_STATE = 0.
- Shift 8'h11, 8'h22, 8'h33, 8'h44 back-to-back with DEPTH = 4 and no RD -> FULL_STATE = 1, DATA = 8'h11. Shift a 5th byte 8'h55 -> OVERRUN = 1, then 4 RD pops yield 11, 22, 33, 44 and EMPTY_STATE = 1.
- FIFO full, 5th byte's last bit coincides with RD = 1 -> no OVERRUN; pop sequence 22, 33, 44, 55.
- Shift 5 bits of 8'hFF, drop SH for 1 cycle, then shift 8'h3C -> single entry DATA = 8'h3C.
- CLR asserted after 4 bits of a byte while 2 bytes are queued -> next edge: EMPTY_STATE = 1, DATA = 8'h00, OVERRUN = 0; the next full byte 8'hC3 is received correctly.
- With RECEIVER_PARITY_EN: send 8'h03 + parity 0 -> PERR = 0. Then send 8'h01 + parity 0 -> DATA queue holds 8'h01 and PERR = 1 (sticky until CLR).
